mem_access_unit: RTL

- Memory stage directly downstream of the load/store address-generation stage.
- Consumes its registered request (addr, cmd, lane-shifted store data, size, bubble) and runs one transaction on the data bus using a req/ack handshake.
- Stalls the pipeline until the bus acknowledges, then aligns and sign/zero-extends load data and presents a registered writeback to the register file.
- Also detects misaligned accesses and bus timeouts.

---
 rtl/mem_access_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Memory stage: runs one req/ack data-bus transaction per accepted load/store,
// stalls upstream while waiting, and returns aligned, extended load data.
module mem_access_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clock_i,
  input  logic            nreset_i,
  input  logic            bubble_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] mem_addr_i,
  input  logic            mem_cmd_i,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic [1:0]      mem_size_i,
  input  logic            mem_unsigned_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  output logic [3:0]      dbus_be_o,
  input  logic            dbus_ack_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic r;
    case (size)
      2'd0:    r = 1'b0;
      2'd1:    r = lo[0];
      2'd2:    r = (lo != 2'd0);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] r;
    case (size)
      2'd0:    r = 4'b0001 << lo;
      2'd1:    r = 4'b0011 << lo;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Picks the addressed byte/halfword out of the bus word and extends it.
  function automatic logic signed [XLEN-1:0] extend_load(input logic [XLEN-1:0] rdata,
                                                         input logic [1:0] lane,
                                                         input logic [1:0] size,
                                                         input logic uns);
    logic [7:0]              b;
    logic [15:0]             h;
    logic                    fill;
    logic signed [XLEN-1:0]  r;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h    = lane[1] ? rdata[31:16] : rdata[15:0];
    fill = 1'b0;
    case (size)
      2'd0: begin
        fill = b[7] & ~uns;
        r    = {{(XLEN-8){fill}}, b};
      end
      2'd1: begin
        fill = h[15] & ~uns;
        r    = {{(XLEN-16){fill}}, h};
      end
      default: r = rdata;
    endcase
    return r;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  to_cnt;
  logic              flush_p1;
  logic [1:0]        lane_p1;
  logic [1:0]        size_p1;
  logic              uns_p1;
  logic [4:0]        rd_p1;

  logic              accept;
  logic              misaligned;
  logic              start;
  logic              ack_busy;
  logic              timeout_hit;
  logic              wb_fire;

  assign accept      = (state == IDLE) && !bubble_i && !flush_i;
  assign misaligned  = is_misaligned(mem_size_i, mem_addr_i[1:0]);
  assign start       = accept && !misaligned;
  assign ack_busy    = (state == BUSY) && dbus_ack_i;
  assign timeout_hit = TO_EN && (state == BUSY) && !dbus_ack_i && (to_cnt == LIMIT);
  // A flush seen in the ack cycle itself must also cancel the writeback.
  assign wb_fire     = ack_busy && !dbus_we_o && !flush_p1 && !flush_i;

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stall_o    = 1'b0;
    dbus_req_o = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = BUSY;
      end
      BUSY: begin
        dbus_req_o = 1'b1;
        stall_o    = !dbus_ack_i;
        if (ack_busy || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: bus request registers and transaction bookkeeping
  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      dbus_we_o    <= 1'b0;
      dbus_addr_o  <= '0;
      dbus_wdata_o <= '0;
      dbus_be_o    <= 4'b0000;
      to_cnt       <= '0;
      flush_p1     <= 1'b0;
    end else begin
      if (start) begin
        dbus_we_o    <= mem_cmd_i;
        dbus_addr_o  <= {mem_addr_i[XLEN-1:2], 2'b00};
        dbus_wdata_o <= mem_data_i;
        dbus_be_o    <= byte_enable(mem_size_i, mem_addr_i[1:0]);
        to_cnt       <= '0;
        flush_p1     <= 1'b0;
      end else if (state == BUSY) begin
        if (!dbus_ack_i && !timeout_hit) to_cnt <= to_cnt + 1'b1;
        if (flush_i) flush_p1 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (start) begin
      lane_p1 <= mem_addr_i[1:0];
      size_p1 <= mem_size_i;
      uns_p1  <= mem_unsigned_i;
      rd_p1   <= rd_i;
    end
  end

  // Stage p2: writeback and status pulses
  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wb_valid_o <= 1'b0;
      wb_rd_o    <= 5'd0;
      wb_data_o  <= '0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      wb_valid_o <= wb_fire;
      misalign_o <= accept && misaligned;
      bus_err_o  <= timeout_hit;
      if (wb_fire) begin
        wb_rd_o   <= rd_p1;
        wb_data_o <= extend_load(dbus_rdata_i, lane_p1, size_p1, uns_p1);
      end
    end
  end

endmodule
